r22_sdf_stage: RTL

Single parametrised radix-2² single-delay-feedback (R2²SDF) butterfly stage, the reusable building block for the next-generation FFT pipeline.
- One instance implements either the BF2I or the BF2II butterfly, with a configurable delay depth, optional 1/2 scaling, an asynchronous active-low reset, and automatic drain of the feedback delay after a stream ends.
- A chain of stages, plus the twiddle multipliers placed between them, forms an N-point FFT.

---
 rtl/sdf_pkg.sv | 31 +++
 rtl/sdf_delay_line.sv | 30 +++
 rtl/r22_sdf_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sdf_pkg.sv
// Shared constants and helpers for the radix-2^2 single-delay-feedback FFT stages.
package sdf_pkg;

    localparam int MODE_BF2I  = 0;
    localparam int MODE_BF2II = 1;

    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Negation that maps the most negative w-bit value onto the most positive one.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (w - 1));
        if (v == lo) begin
            return -lo - 32'sd1;
        end else begin
            return -v;
        end
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Enable-gated feedback delay of complex words; output is the word written DEPTH enabled cycles ago.
module sdf_delay_line
    import sdf_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [DW-1:0] din_re_i,
    input  logic [DW-1:0] din_im_i,
    output logic [DW-1:0] dout_re_o,
    output logic [DW-1:0] dout_im_o
);

    logic [2*DW-1:0] taps_q [DEPTH];

    // Contents are deliberately not reset; the stage's pending count masks stale words.
    always_ff @(posedge clk) begin
        if (en_i) begin
            taps_q[0] <= {din_re_i, din_im_i};
            for (int i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign {dout_re_o, dout_im_o} = taps_q[DEPTH-1];

endmodule

// File: rtl/r22_sdf_stage.sv
// One R2^2 SDF butterfly stage (BF2I or BF2II) with optional halving and self-draining feedback delay.
module r22_sdf_stage
    import sdf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int MODE  = 0,
    parameter int SCALE = 1,
    parameter int OW    = WIDTH + 1 - SCALE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             enable_out,
    output logic [OW-1:0]    out_re,
    output logic [OW-1:0]    out_im
);

    localparam int DW = WIDTH + 1;
    localparam int LM = log2c(DEPTH);
    localparam int BL = (MODE == MODE_BF2II) ? 4 * DEPTH : 2 * DEPTH;
    localparam int CW = log2c(BL);
    localparam int PW = log2c(DEPTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pend_q, pend_d;
    logic             en_out_q, en_out_d;
    logic [OW-1:0]    re_q, re_d, im_q, im_d;
    logic             phase_s, rot_s, adv_s, pend_nz_s, valid_s;
    logic [WIDTH-1:0] src_re_s, src_im_s, neg_re_s, x_re_s, x_im_s;
    logic [DW-1:0]    xe_re_s, xe_im_s, dl_re_s, dl_im_s;
    logic [DW-1:0]    din_re_s, din_im_s, res_re_s, res_im_s;

    assign phase_s   = cnt_q[LM];
    assign pend_nz_s = (pend_q != '0);
    assign adv_s     = enable_in | (~phase_s & pend_nz_s);
    // Drain advances feed zeros so the delay line keeps flushing cleanly.
    assign src_re_s  = enable_in ? in_re : '0;
    assign src_im_s  = enable_in ? in_im : '0;
    assign neg_re_s  = WIDTH'(sat_neg(32'($signed(src_re_s)), WIDTH));

    if (MODE == MODE_BF2II) begin : g_rot
        assign rot_s = (cnt_q[CW-1 -: 2] == 2'b11);
    end else begin : g_no_rot
        assign rot_s = 1'b0;
    end

    sdf_delay_line #(.DEPTH(DEPTH), .DW(DW)) u_delay (
        .clk       (clk),
        .en_i      (adv_s),
        .din_re_i  (din_re_s),
        .din_im_i  (din_im_s),
        .dout_re_o (dl_re_s),
        .dout_im_o (dl_im_s)
    );

    // Butterfly datapath: fill the delay in phase 0, sum/difference in phase 1.
    always_comb begin
        if (rot_s) begin
            x_re_s = src_im_s;
            x_im_s = neg_re_s;
        end else begin
            x_re_s = src_re_s;
            x_im_s = src_im_s;
        end
        xe_re_s = {x_re_s[WIDTH-1], x_re_s};
        xe_im_s = {x_im_s[WIDTH-1], x_im_s};
        if (phase_s) begin
            res_re_s = dl_re_s + xe_re_s;
            res_im_s = dl_im_s + xe_im_s;
            din_re_s = dl_re_s - xe_re_s;
            din_im_s = dl_im_s - xe_im_s;
            valid_s  = 1'b1;
        end else begin
            res_re_s = dl_re_s;
            res_im_s = dl_im_s;
            din_re_s = xe_re_s;
            din_im_s = xe_im_s;
            valid_s  = pend_nz_s;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        en_out_d = 1'b0;
        re_d     = re_q;
        im_d     = im_q;
        if (adv_s) begin
            cnt_d    = cnt_q + CW'(1);
            en_out_d = valid_s;
            if (phase_s && (cnt_q == CW'(BL - 1))) begin
                pend_d = PW'(DEPTH);
            end else if (!phase_s && pend_nz_s) begin
                pend_d = pend_q - PW'(1);
            end else begin
                pend_d = pend_q;
            end
            if (valid_s) begin
                re_d = OW'($signed(res_re_s) >>> SCALE);
                im_d = OW'($signed(res_im_s) >>> SCALE);
            end else begin
                re_d = re_q;
                im_d = im_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            pend_q   <= '0;
            en_out_q <= 1'b0;
            re_q     <= '0;
            im_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            en_out_q <= en_out_d;
            re_q     <= re_d;
            im_q     <= im_d;
        end
    end

    assign enable_out = en_out_q;
    assign out_re     = re_q;
    assign out_im     = im_q;

endmodule
